// File: rtl/param_fixed_point_divider_pkg.sv
// Shared types and sizing helpers for the parametrised restoring divider.
// Module parameters override the defaults; the helpers derive the iteration count and counter width.
package param_fixed_point_divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 10;
    localparam int FRAC_DEF  = 4;
    localparam int N_DEF     = WIDTH_DEF + FRAC_DEF;
    localparam int CNT_W_DEF = $clog2(N_DEF + 1);

    function automatic int iter_count(input int width, input int frac);
        return width + frac;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/param_fixed_point_divider_if.sv
// Start/busy/done handshake and operand/result bus of the fixed-point divider.
interface param_fixed_point_divider_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic             ld_a;
    logic             ld_b;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q_next;
    logic             ov;
    logic             dz;

    modport master (
        output start, ld_a, ld_b, A, B,
        input  busy, done, Q_next, ov, dz
    );

    modport slave (
        input  start, ld_a, ld_b, A, B,
        output busy, done, Q_next, ov, dz
    );
endinterface

// File: rtl/param_fixed_point_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit and conditionally subtract.
module div_step_unit #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH:0]   acc,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   acc_next,
    output logic             q_bit
);

    logic [WIDTH:0] acc_shift;
    logic           unused_acc_msb;

    // The remainder is always below the divisor, so its top bit never carries information.
    assign unused_acc_msb = acc[WIDTH];

    always_comb begin
        acc_shift = {acc[WIDTH-1:0], din};
        if (acc_shift >= {1'b0, divisor}) begin
            acc_next = acc_shift - {1'b0, divisor};
            q_bit    = 1'b1;
        end else begin
            acc_next = acc_shift;
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/param_fixed_point_divider.sv
// Multi-cycle unsigned fixed-point divider: Q = (A << FRAC) / B over N = WIDTH+FRAC iterations.
// state  | meaning
// IDLE   | waiting for start; operands may be loaded
// DIVIDE | one quotient bit per cycle from the snapshotted operands
// DONE   | one-cycle done pulse; results already registered
module param_fixed_point_divider
    import param_fixed_point_divider_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int SATURATE = 1
) (
    input logic                          clk,
    input logic                          rst,
    param_fixed_point_divider_if.slave   bus
);

    localparam int N     = iter_count(WIDTH, FRAC);
    localparam int CNT_W = cnt_width(N);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, div_snap;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [N-1:0]     shreg, qf_final;
    logic [CNT_W-1:0] cnt;
    logic             q_bit, last_iter, ov_full;
    logic [WIDTH-1:0] q_final, q_reg;
    logic             ov_reg, dz_reg;

    div_step_unit #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .din      (shreg[N-1]),
        .divisor  (div_snap),
        .acc_next (acc_nxt),
        .q_bit    (q_bit)
    );

    assign last_iter = (cnt == CNT_W'(N - 1));
    assign qf_final  = {shreg[N-2:0], q_bit};
    assign ov_full   = |qf_final[N-1:WIDTH];
    assign q_final   = (ov_full && SATURATE != 0) ? {WIDTH{1'b1}} : qf_final[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) state_nxt = (b_reg == '0) ? DONE : DIVIDE;
            end
            DIVIDE: begin
                if (last_iter) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            div_snap <= '0;
            acc      <= '0;
            shreg    <= '0;
            cnt      <= '0;
            q_reg    <= '0;
            ov_reg   <= 1'b0;
            dz_reg   <= 1'b0;
        end else begin
            if (bus.ld_a) a_reg <= bus.A;
            if (bus.ld_b) b_reg <= bus.B;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (b_reg != '0) begin
                            shreg    <= {a_reg, {FRAC{1'b0}}};
                            div_snap <= b_reg;
                            acc      <= '0;
                            cnt      <= '0;
                        end else begin
                            dz_reg <= 1'b1;
                            ov_reg <= 1'b1;
                            q_reg  <= (SATURATE != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                        end
                    end
                end
                DIVIDE: begin
                    // Quotient bits enter at the LSB as dividend bits leave the MSB.
                    acc   <= acc_nxt;
                    shreg <= qf_final;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        q_reg  <= q_final;
                        ov_reg <= ov_full;
                        dz_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == DIVIDE);
    assign bus.done   = (state == DONE);
    assign bus.Q_next = q_reg;
    assign bus.ov     = ov_reg;
    assign bus.dz     = dz_reg;

endmodule

// File: doc/param_fixed_point_divider.md
Name: param_fixed_point_divider

Overview:
- Parametrised, handshaked successor to the 10-bit fixed-point divider.
- Performs unsigned restoring division of two WIDTH-bit operands and returns a quotient with FRAC fractional bits.
- Reports overflow and divide-by-zero, with optional saturation.
- Sits in the datapath as a multi-cycle arithmetic unit behind operand registers, driven by a start/busy/done handshake.

Parameters:
- WIDTH, 10, operand and quotient width in bits.
- FRAC, 4, fractional bits of the quotient; iteration count N = WIDTH+FRAC.
- SATURATE, 1, 1: quotient forced to all-ones on overflow or divide-by-zero; 0: quotient is the truncated low WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin division; sampled only in IDLE.
- ld_a  input  1  load A into operand register A.
- ld_b  input  1  load B into operand register B.
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- busy  output  1  high while a division is in flight (DIVIDE state).
- done  output  1  one-cycle pulse; Q_next/ov/dz valid from this cycle.
- Q_next  output  WIDTH  quotient, unsigned fixed point with FRAC fractional bits.
- ov  output  1  quotient overflow (result >= 2^WIDTH in WIDTH-bit fixed point) or divide-by-zero.
- dz  output  1  divide-by-zero flag.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - Operand registers, accumulator, shift register and counter clear to 0.
  - busy=0, done=0, Q_next=0, ov=0, dz=0.
  - Applies mid-operation: the in-flight result is discarded and done is never issued for it.
- Operand registers:
  - Load on ld_a/ld_b in any state.
  - ld and start in the same cycle: start uses the old register value.
- States IDLE, DIVIDE, DONE. Counter width is $clog2(N+1).
- IDLE, start=1, B_reg!=0:
  - Snapshot: dividend shift register (N bits) = A_reg<<FRAC, divisor snapshot = B_reg.
  - Accumulator (WIDTH+1 bits) = 0, counter = 0.
  - Go to DIVIDE.
- IDLE, start=1, B_reg==0:
  - Go to DONE with dz=1, ov=1.
  - Q_next = all-ones if SATURATE, else 0.
- DIVIDE, each cycle:
  - acc' = {acc[WIDTH-1:0], msb of shift reg}; shift reg shifts left.
  - If acc' >= divisor: acc = acc' − divisor and shift in quotient bit 1; else acc = acc' and shift in 0.
  - After N iterations (counter == N−1 on that edge) go to DONE.
- Quotient width and overflow:
  - The full quotient qf is N bits.
  - ov = |qf[N−1:WIDTH].
  - Q_next = (ov && SATURATE) ? all-ones : qf[WIDTH−1:0].
- DONE:
  - done=1 for exactly one cycle; Q_next/ov/dz registered on entry; return to IDLE unconditionally.
- Latency:
  - done is high in the cycle after the Nth edge following the start-sampling edge, i.e. N cycles.
  - Divide-by-zero latency is 1 cycle.
- Outputs Q_next/ov/dz hold their values until the next DONE; they are not cleared on start.
- start while busy or in DONE is ignored (no queueing).
- Operand changes during DIVIDE do not affect the in-flight result (snapshot).
- Remainder is discarded; truncation is toward zero.

Decomposition:
- Shared package holds:
  - State enum {IDLE, DIVIDE, DONE}.
  - N = WIDTH+FRAC.
  - CNT_W = $clog2(N+1).
- One natural sub-module: div_step_unit. It is combinational with inputs acc, next dividend bit and divisor, and outputs new acc and quotient bit.
- Top level holds the FSM, counter, operand/snapshot registers and output registers.

Test Plan:
- WIDTH=10, FRAC=4, A=6, B=4, start → done exactly 14 cycles after the start edge; Q_next=24 (1.5), ov=0, dz=0; busy high for 14 cycles.
- A=1, B=3 → Q_next=5 (0.3125, truncated), ov=0.
- A=1023, B=1 → ov=1; Q_next=1023 with SATURATE=1; Q_next=1008 with SATURATE=0.
- B=0, A=7, start → done after 1 cycle; dz=1, ov=1, Q_next=1023 (SATURATE=1).
- Start A=6, B=4. Assert start again and ld_a with A=100 at cycle 5 → second start ignored, result still 24, single done pulse.
- Start a division, drive rst low at cycle 7 → all outputs 0 immediately (async), no done. After release, a new start with A=9, B=3 gives Q_next=48.
